// File: rtl/check_p.sv
// Registered primality classifier: one-cycle latency, decode is a constant
// table built at elaboration, so no divider exists in hardware.
module check_p #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] n,
    output logic             out_valid,
    output logic             isP
);

    localparam int DEPTH = 1 << WIDTH;

    // Trial division runs only at elaboration; every entry resolves to 0 or 1.
    function automatic logic [DEPTH-1:0] build_table();
        logic [DEPTH-1:0] t;
        logic             p;
        t = '0;
        for (int k = 2; k < DEPTH; k++) begin
            p = 1'b1;
            for (int d = 2; d * d <= k; d++) begin
                if ((k % d) == 0) p = 1'b0;
            end
            t[k] = p;
        end
        return t;
    endfunction

    localparam logic [DEPTH-1:0] PRIME_TBL = build_table();

    logic isP_q, isP_d;
    logic out_valid_q, out_valid_d;

    always_comb begin
        out_valid_d = in_valid;
        isP_d       = isP_q;
        if (in_valid) isP_d = PRIME_TBL[n];
    end

    // Stage p0 -> output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isP_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            isP_q       <= isP_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign isP       = isP_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_check_p.sv
// Directed bench for check_p at WIDTH=3 and WIDTH=5 with hand-computed results.
module tb_check_p;

    logic       clk = 1'b0;
    logic       rst;
    logic       v3, v5;
    logic [2:0] n3;
    logic [4:0] n5;
    logic       ov3, p3, ov5, p5;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    check_p #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .n(n3),
        .out_valid(ov3), .isP(p3)
    );

    check_p #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .n(n5),
        .out_valid(ov5), .isP(p5)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step3(input logic v, input logic [2:0] val);
        @(negedge clk);
        v3 = v; n3 = val; v5 = 1'b0; n5 = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic step5(input logic [4:0] val);
        @(negedge clk);
        v5 = 1'b1; n5 = val; v3 = 1'b0; n3 = '0;
        @(posedge clk);
        #1;
    endtask

    logic exp_sweep [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rst = 1'b1; v3 = 1'b0; v5 = 1'b0; n3 = '0; n5 = '0;
        #2;
        check("rst_isP3", p3, 1'b0);
        check("rst_ov3", ov3, 1'b0);
        check("rst_isP5", p5, 1'b0);
        check("rst_ov5", ov5, 1'b0);
        @(posedge clk); #1;
        check("rst_hold_isP3", p3, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // First edge after release samples normally
        step3(1'b1, 3'd2);
        check("post_rst_isP", p3, 1'b1);
        check("post_rst_ov", ov3, 1'b1);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("async_isP", p3, 1'b0);
        check("async_ov", ov3, 1'b0);
        @(posedge clk); #1;
        check("async_hold_isP", p3, 1'b0);
        check("async_hold_ov", ov3, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            step3(1'b1, 3'(i));
            check($sformatf("sweep_isP_%0d", i), p3, exp_sweep[i]);
            check($sformatf("sweep_ov_%0d", i), ov3, 1'b1);
        end

        step3(1'b1, 3'd5);
        check("hold_pre_isP", p3, 1'b1);
        step3(1'b0, 3'd4);
        check("hold_isP", p3, 1'b1);
        check("hold_ov", ov3, 1'b0);

        step3(1'b1, 3'd6);
        check("rep6a_isP", p3, 1'b0);
        step3(1'b1, 3'd6);
        check("rep6b_isP", p3, 1'b0);
        check("rep6b_ov", ov3, 1'b1);
        step3(1'b1, 3'd1);
        check("ret1_isP", p3, 1'b0);
        step3(1'b1, 3'd3);
        check("ret3_isP", p3, 1'b1);

        // n=7 in flight when reset pulses
        @(negedge clk);
        v3 = 1'b1; n3 = 3'd7;
        #2 rst = 1'b1;
        #1;
        check("mid_isP", p3, 1'b0);
        check("mid_ov", ov3, 1'b0);
        @(posedge clk); #1;
        check("mid_hold_isP", p3, 1'b0);
        check("mid_hold_ov", ov3, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step3(1'b1, 3'd2);
        check("mid_rel_isP", p3, 1'b1);
        check("mid_rel_ov", ov3, 1'b1);

        step5(5'd25); check("w5_25", p5, 1'b0); check("w5_ov", ov5, 1'b1);
        step5(5'd29); check("w5_29", p5, 1'b1);
        step5(5'd31); check("w5_31", p5, 1'b1);
        step5(5'd27); check("w5_27", p5, 1'b0);
        step5(5'd0);  check("w5_0", p5, 1'b0);
        step5(5'd2);  check("w5_2", p5, 1'b1);
        step5(5'd9);  check("w5_9", p5, 1'b0);
        step5(5'd1);  check("w5_1", p5, 1'b0);
        step5(5'd23); check("w5_23", p5, 1'b1);
        @(negedge clk);
        v5 = 1'b0; n5 = 5'd4;
        @(posedge clk); #1;
        check("w5_hold_isP", p5, 1'b1);
        check("w5_hold_ov", ov5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/check_p.md
Name: check_p

Overview:
- Registered primality detector: reports whether the unsigned input word `n` is a prime number.
- Sits as a small classification leaf in datapath logic.
- Result is registered on `clk` with one-cycle latency and a valid flag tracking the input strobe.
- Default width is 3 bits (values 0..7); primes are 2, 3, 5, 7.

Parameters:
- WIDTH, 3, bit width of `n`; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `n` carries a value to classify this cycle.
- n  input  WIDTH  unsigned value to test.
- out_valid  output  1  `isP` holds a fresh result this cycle.
- isP  output  1  1 = registered `n` is prime, 0 = not prime.

Behaviour:
- Primality definition:
  - 0 and 1 are not prime.
  - k >= 2 is prime iff no integer d with 2 <= d <= floor(sqrt(k)) divides k.
- Decode: combinational decode `prime(n)` covers every value 0..2^WIDTH-1.
  - Built as an elaboration-time table, e.g. a constant function running trial division.
  - No runtime division logic.
- For WIDTH=3: prime(n)=1 for n in {2,3,5,7}; 0 for {0,1,4,6}.
- Reset (rst=1, asynchronous, any time):
  - `isP` <= 0 and `out_valid` <= 0 immediately, independent of `clk`.
  - Both hold while rst is high.
- Normal operation, each rising `clk` with rst=0:
  - `out_valid` <= `in_valid`.
  - If `in_valid`=1: `isP` <= prime(n).
  - If `in_valid`=0: `isP` holds its previous value; `out_valid` drops to 0.
- Latency:
  - Exactly 1 cycle from sampling `n` to the result on `isP`.
  - Throughput 1 result per cycle; back-to-back inputs are allowed.
- Repeated values: a repeated identical `n` produces an identical result with `out_valid`=1 each cycle.
- Reset release:
  - The first rising edge after rst falls samples inputs normally.
  - No extra wait cycles.
- Reset asserted mid-stream: the in-flight result is discarded; outputs go to 0.
- Width rules:
  - `n` is treated as unsigned.
  - The table has exactly 2^WIDTH entries; there is no out-of-range case.
- No X propagation from the table: every entry is defined 0 or 1.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> `isP`=0 and `out_valid`=0 before the next edge; both stay 0 while rst=1.
- Exhaustive sweep, WIDTH=3, `in_valid`=1: drive n=0,1,2,3,4,5,6,7 on consecutive edges -> one cycle later `isP`=0,0,1,1,0,1,0,1 with `out_valid`=1 throughout.
- Hold behaviour: drive n=5 valid, then `in_valid`=0 with n=4 -> `isP` stays 1, `out_valid`=0.
- Repeat/return: drive n=6 then n=1 -> `isP`=0, 0; then n=3 -> `isP`=1.
- Mid-stream reset: during the sweep, pulse rst while n=7 is in flight -> `isP`=0 and `out_valid`=0; after release, n=2 -> `isP`=1 next cycle.
- Wider config, WIDTH=5: n=25 -> 0, 29 -> 1, 31 -> 1, 27 -> 0, 0 -> 0.
